// File: rtl/multicycle_sequencer.sv
// Single-clock multi-cycle control sequencer for the LEGv8 core: steps each instruction
// through FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK with one-cycle stage strobes.
module multicycle_sequencer #(
    parameter int          INSTR_LEN   = 32,
    parameter logic [10:0] HALT_OPCODE = 11'h6A2,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          MAX_INSTR   = 0,
    parameter int          CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 reg_write,
    input  logic                 mem_ready,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 execute_en,
    output logic                 mem_req,
    output logic                 wb_en,
    output logic                 pc_en,
    output logic                 busy,
    output logic                 halted,
    output logic                 error,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     retired,
    output logic [CNT_W-1:0]     cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W:0]    LIMIT     = (CNT_W + 1)'(MAX_INSTR);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_fetch_en;
    logic               r_decode_en;
    logic               r_execute_en;
    logic               r_mem_req;
    logic               r_wb_en;
    logic               r_pc_en;
    logic               r_busy;
    logic               r_halted;
    logic               r_error;
    logic [CNT_W-1:0]   r_retired;
    logic [CNT_W-1:0]   r_cycles;
    logic               r_halt_pend;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [10:0]        r_opcode_q;
    logic               r_mr_q;
    logic               r_mw_q;
    logic               r_rw_q;
    logic [10:0]        w_opcode;
    logic               w_is_halt;
    logic               w_wait_last;
    logic               w_limit_hit;
    logic               w_front_half;
    logic               w_unused;

    assign w_opcode     = instruction[INSTR_LEN-1 -: 11];
    assign w_is_halt    = (w_opcode == HALT_OPCODE);
    assign w_wait_last  = (r_wait_cnt == WAIT_LAST);
    assign w_front_half = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                          (r_state == S_EXECUTE) || (r_state == S_MEMORY);
    // The retire limit looks at the count this WRITEBACK is about to produce.
    assign w_limit_hit  = (MAX_INSTR != 0) &&
                          (({1'b0, r_retired} + {{CNT_W{1'b0}}, 1'b1}) == LIMIT);
    assign w_unused     = ^{instruction[INSTR_LEN-12:0], r_opcode_q};

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (start) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH:   w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (r_mr_q || r_mw_q) begin
                    w_state_nxt = S_MEMORY;
                end else begin
                    w_state_nxt = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    w_state_nxt = S_WRITEBACK;
                end else if (w_wait_last) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_state_nxt = S_MEMORY;
                end
            end
            S_WRITEBACK: begin
                if (r_halt_pend || halt_req || w_limit_hit) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT:    w_state_nxt = S_HALT;
            S_ERROR:   w_state_nxt = S_ERROR;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State register; strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fetch_en   <= 1'b0;
            r_decode_en  <= 1'b0;
            r_execute_en <= 1'b0;
            r_mem_req    <= 1'b0;
            r_wb_en      <= 1'b0;
            r_pc_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_en   <= (w_state_nxt == S_FETCH);
            r_decode_en  <= (w_state_nxt == S_DECODE);
            r_execute_en <= (w_state_nxt == S_EXECUTE);
            r_mem_req    <= (w_state_nxt == S_MEMORY);
            r_wb_en      <= (w_state_nxt == S_WRITEBACK) && r_rw_q;
            r_pc_en      <= (w_state_nxt == S_WRITEBACK);
            r_busy       <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DECODE) ||
                            (w_state_nxt == S_EXECUTE) || (w_state_nxt == S_MEMORY) ||
                            (w_state_nxt == S_WRITEBACK);
            r_halted     <= (w_state_nxt == S_HALT);
            r_error      <= (w_state_nxt == S_ERROR);
        end
    end

    // Decode-time capture of the instruction's control bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode_q <= 11'h000;
            r_mr_q     <= 1'b0;
            r_mw_q     <= 1'b0;
            r_rw_q     <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_opcode_q <= w_opcode;
            r_mr_q     <= mem_read;
            r_mw_q     <= mem_write;
            r_rw_q     <= reg_write;
        end else begin
            r_opcode_q <= r_opcode_q;
            r_mr_q     <= r_mr_q;
            r_mw_q     <= r_mw_q;
            r_rw_q     <= r_rw_q;
        end
    end

    // Memory wait counter: zero on entry to MEMORY, counts each cycle spent there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (r_state == S_MEMORY) begin
            r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end
    end

    // Sticky stop request so the in-flight instruction can finish first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halt_pend <= 1'b0;
        end else if (w_state_nxt == S_HALT) begin
            r_halt_pend <= 1'b0;
        end else if (halt_req && w_front_half) begin
            r_halt_pend <= 1'b1;
        end else begin
            r_halt_pend <= r_halt_pend;
        end
    end

    // Saturating retire and active-cycle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= {CNT_W{1'b0}};
            r_cycles  <= {CNT_W{1'b0}};
        end else begin
            if ((r_state == S_WRITEBACK) && (r_retired != {CNT_W{1'b1}})) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_retired <= r_retired;
            end
            if (r_busy && (r_cycles != {CNT_W{1'b1}})) begin
                r_cycles <= r_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cycles <= r_cycles;
            end
        end
    end

    assign fetch_en   = r_fetch_en;
    assign decode_en  = r_decode_en;
    assign execute_en = r_execute_en;
    assign mem_req    = r_mem_req;
    assign wb_en      = r_wb_en;
    assign pc_en      = r_pc_en;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign error      = r_error;
    assign state      = r_state;
    assign retired    = r_retired;
    assign cycles     = r_cycles;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_multicycle_sequencer;

    localparam int TO = 4;
    localparam logic [31:0] I_ADD  = {11'h458, 21'h01234};
    localparam logic [31:0] I_LDUR = {11'h7C2, 21'h00456};
    localparam logic [31:0] I_STUR = {11'h7C0, 21'h00789};
    localparam logic [31:0] I_HALT = {11'h6A2, 21'h00000};

    logic        clk = 1'b0;
    logic        reset, start, halt_req, mr, mw, rw, rdy;
    logic [31:0] ins;
    logic        fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, busy, halted, error;
    logic [2:0]  state;
    logic [31:0] retired, cycles;
    logic        l_fetch_en, l_decode_en, l_execute_en, l_mem_req, l_wb_en, l_pc_en;
    logic        l_busy, l_halted, l_error;
    logic [2:0]  l_state;
    logic [31:0] l_retired, l_cycles;

    int n_pass = 0;
    int n_total = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .MAX_INSTR(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .instruction(ins),
        .mem_read(mr), .mem_write(mw), .reg_write(rw), .mem_ready(rdy),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en), .mem_req(mem_req),
        .wb_en(wb_en), .pc_en(pc_en), .busy(busy), .halted(halted), .error(error),
        .state(state), .retired(retired), .cycles(cycles));

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .MAX_INSTR(3)) u_lim (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .instruction(ins),
        .mem_read(mr), .mem_write(mw), .reg_write(rw), .mem_ready(rdy),
        .fetch_en(l_fetch_en), .decode_en(l_decode_en), .execute_en(l_execute_en),
        .mem_req(l_mem_req), .wb_en(l_wb_en), .pc_en(l_pc_en), .busy(l_busy),
        .halted(l_halted), .error(l_error), .state(l_state), .retired(l_retired),
        .cycles(l_cycles));

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] in;
        logic        m_r, m_w, r_w, rd;
        logic [2:0]  e_state;
        logic        e_wb;
        logic [31:0] e_ret, e_cyc;
    } vec_t;

    vec_t tbl[16];

    // Reference model state
    int          m_st, m_memn;
    logic        m_hp, m_mr, m_mw, m_rw;
    logic [31:0] m_ret, m_cyc;

    logic        found;
    logic [2:0]  prev;
    int          nwb, nmreq;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] exp_strb(input logic [2:0] s, input logic w);
        return {s == 3'd1, s == 3'd2, s == 3'd3, s == 3'd4, w, s == 3'd5,
                (s >= 3'd1) && (s <= 3'd5), s == 3'd6, s == 3'd7};
    endfunction

    function automatic logic [8:0] act_strb();
        return {fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, busy, halted, error};
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; halt_req = 1'b0;
        mr = 1'b0; mw = 1'b0; rw = 1'b0; rdy = 1'b0; ins = I_ADD;
        tick();
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_st = 0; m_memn = 0; m_hp = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0;
        m_ret = 32'd0; m_cyc = 32'd0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_step();
        int nst;
        nst = m_st;
        if (m_st == 0) nst = halt_req ? 6 : (start ? 1 : 0);
        else if (m_st == 1) nst = 2;
        else if (m_st == 2) begin
            m_mr = mr; m_mw = mw; m_rw = rw;
            nst = (ins[31:21] == 11'h6A2) ? 6 : 3;
        end else if (m_st == 3) begin
            m_memn = 0;
            nst = (m_mr || m_mw) ? 4 : 5;
        end else if (m_st == 4) begin
            if (rdy) nst = 5;
            else begin
                m_memn = m_memn + 1;
                nst = (m_memn == TO) ? 7 : 4;
            end
        end else if (m_st == 5) begin
            if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
            nst = (m_hp || halt_req) ? 6 : 1;
        end
        if (m_st >= 1 && m_st <= 4 && halt_req) m_hp = 1'b1;
        if (nst == 6) m_hp = 1'b0;
        if (m_st >= 1 && m_st <= 5 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
        m_st = nst;
    endtask

    initial begin
        // ADD (rw), LDUR with 3 MEMORY cycles (ready seen in EXECUTE is ignored), ADD (no rw)
        tbl[0]  = '{1'b1, I_ADD,  1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 32'd0, 32'd0};
        tbl[1]  = '{1'b0, I_ADD,  1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 32'd0, 32'd1};
        tbl[2]  = '{1'b0, I_ADD,  1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 32'd0, 32'd2};
        tbl[3]  = '{1'b0, I_ADD,  1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 32'd0, 32'd3};
        tbl[4]  = '{1'b0, I_LDUR, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 32'd1, 32'd4};
        tbl[5]  = '{1'b0, I_LDUR, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 32'd1, 32'd5};
        tbl[6]  = '{1'b0, I_LDUR, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 32'd1, 32'd6};
        tbl[7]  = '{1'b0, I_LDUR, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 32'd1, 32'd7};
        tbl[8]  = '{1'b0, I_LDUR, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 32'd1, 32'd8};
        tbl[9]  = '{1'b0, I_LDUR, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 32'd1, 32'd9};
        tbl[10] = '{1'b0, I_LDUR, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 32'd1, 32'd10};
        tbl[11] = '{1'b0, I_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'd2, 32'd11};
        tbl[12] = '{1'b0, I_ADD,  1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 32'd2, 32'd12};
        tbl[13] = '{1'b0, I_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'd2, 32'd13};
        tbl[14] = '{1'b0, I_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 32'd2, 32'd14};
        tbl[15] = '{1'b0, I_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'd3, 32'd15};

        // Reset state
        do_reset();
        chk("reset_state", 80'(state), 80'(3'd0));
        chk("reset_strobes", 80'(act_strb()), 80'(9'd0));
        chk("reset_counters", {16'h0, retired, cycles}, 80'd0);
        chk("reset_lim", {l_state, l_busy, l_halted, l_error, l_retired, l_cycles}, 80'd0);
        tick();
        chk("idle_hold", 80'(state), 80'(3'd0));

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].st; ins = tbl[i].in; mr = tbl[i].m_r; mw = tbl[i].m_w;
            rw = tbl[i].r_w; rdy = tbl[i].rd;
            tick();
            chk($sformatf("vec%0d_state", i), 80'(state), 80'(tbl[i].e_state));
            chk($sformatf("vec%0d_strobes", i), 80'(act_strb()),
                80'(exp_strb(tbl[i].e_state, tbl[i].e_wb)));
            chk($sformatf("vec%0d_counters", i), {16'h0, retired, cycles},
                {16'h0, tbl[i].e_ret, tbl[i].e_cyc});
        end

        // STUR with memory never ready: timeout into ERROR, then terminal
        do_reset();
        ins = I_STUR; mw = 1'b1; rw = 1'b0; rdy = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; nmreq = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mem_req) nmreq++;
            if (state == 3'd7) found = 1'b1;
        end
        chk("timeout_reached", 80'(found), 80'(1'b1));
        chk("timeout_mreq_cycles", 80'(nmreq), 80'(TO));
        for (int i = 0; i < 6; i++) begin
            start = ~start; halt_req = i[0]; rdy = ~rdy;
            tick();
        end
        start = 1'b0; halt_req = 1'b0;
        chk("error_terminal", {77'(state), error, busy, mem_req}, {77'(3'd7), 1'b1, 1'b0, 1'b0});
        chk("error_cycles", 80'(cycles), 80'(32'd7));

        // HALT opcode after two ADDs
        do_reset();
        ins = I_ADD; rw = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; found = 1'b0; nwb = 0; prev = 3'd0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (retired == 32'd2) ins = I_HALT;
            prev = state;
            tick();
            if (wb_en) nwb++;
            if (state == 3'd6) found = 1'b1;
        end
        chk("haltop_reached", 80'(found), 80'(1'b1));
        chk("haltop_from_decode", 80'(prev), 80'(3'd2));
        chk("haltop_status", {47'h0, halted, retired}, {47'h0, 1'b1, 32'd2});
        chk("haltop_wb_count", 80'(nwb), 80'(2));
        chk("haltop_cycles", 80'(cycles), 80'(32'd10));

        // halt_req pulsed during EXECUTE: the ADD still retires
        do_reset();
        ins = I_ADD; rw = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (state == 3'd3) found = 1'b1;
        end
        chk("hreq_exec_reached", 80'(found), 80'(1'b1));
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("hreq_wb", {77'(state), wb_en, 2'b0}, {77'(3'd5), 1'b1, 2'b0});
        tick();
        chk("hreq_halt", {45'h0, state, retired}, {45'h0, 3'd6, 32'd1});

        // start and halt_req together in IDLE
        do_reset();
        start = 1'b1; halt_req = 1'b1;
        tick();
        start = 1'b0; halt_req = 1'b0;
        chk("idle_halt_wins", {44'h0, state, halted, retired}, {44'h0, 3'd6, 1'b1, 32'd0});

        // Retire limit of 3
        do_reset();
        ins = I_ADD; rw = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            tick();
            if (l_state == 3'd6) found = 1'b1;
        end
        chk("limit_reached", 80'(found), 80'(1'b1));
        chk("limit_counters", {15'h0, l_halted, l_retired, l_cycles}, {15'h0, 1'b1, 32'd3, 32'd12});

        // Reset mid-MEMORY drops mem_req before the next edge
        do_reset();
        ins = I_ADD; rw = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (retired == 32'd1) found = 1'b1;
        end
        ins = I_LDUR; mr = 1'b1;
        for (int i = 0; i < 20 && found && state != 3'd4; i++) tick();
        chk("midmem_reached", {76'h0, mem_req, state}, {76'h0, 1'b1, 3'd4});
        #2;
        reset = 1'b1;
        #1;
        chk("midmem_reset", {12'h0, mem_req, state, retired, cycles}, 80'd0);
        tick();
        reset = 1'b0;
        mr = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (((m_st == 6 || m_st == 7) && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end else begin
                start    = 1'($urandom_range(0, 1));
                halt_req = ($urandom_range(0, 39) == 0);
                ins      = $urandom;
                if ($urandom_range(0, 15) == 0) ins[31:21] = 11'h6A2;
                mr  = ($urandom_range(0, 2) == 0);
                mw  = ($urandom_range(0, 3) == 0);
                rw  = 1'($urandom_range(0, 1));
                rdy = 1'($urandom_range(0, 1));
                model_step();
                tick();
            end
            chk("random", {4'h0, state, act_strb(), retired, cycles},
                {4'h0, 3'(m_st), exp_strb(3'(m_st), (m_st == 5) && m_rw), m_ret, m_cyc});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
